// File: rtl/ov5640_cap_pkg.sv
// Shared types for the OV5640 capture controller: FSM state encoding and
// the frame-size derivation used to close each captured frame.
package ov5640_cap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        ARM,
        CAPT,
        CLOSE
    } cap_state_t;

    function automatic int unsigned frame_pixels(input int unsigned h_act, input int unsigned v_act);
        return h_act * v_act;
    endfunction

endpackage

// File: rtl/ov5640_vsync_edge.sv
// Registers raw sensor vsync once and flags blanking exit (vs_start) and
// blanking entry (vs_end) against that register, honouring vsync polarity.
module ov5640_vsync_edge #(
    parameter bit VS_POL = 1'b1
) (
    input  logic sysclk,
    input  logic rst,
    input  logic cmos_vsync,
    output logic vs_start,
    output logic vs_end
);

    logic vs_reg;

    // Reset to the blanking level so a sensor idling in blanking yields no edge.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            vs_reg <= VS_POL;
        end else begin
            vs_reg <= cmos_vsync;
        end
    end

    assign vs_start = (vs_reg == VS_POL) && (cmos_vsync != VS_POL);
    assign vs_end   = (vs_reg != VS_POL) && (cmos_vsync == VS_POL);

endmodule

// File: rtl/ov5640_capture_ctrl.sv
// Frames the camera pixel stream into ping-pong SDRAM frame buffers and reports
// per-frame status. Define CAPTURE_DECIM_EN to capture only every second frame.
module ov5640_capture_ctrl
    import ov5640_cap_pkg::*;
#(
    parameter int unsigned       H_ACT       = 640,
    parameter int unsigned       V_ACT       = 480,
    parameter int unsigned       SKIP_FRAMES = 10,
    parameter int unsigned       ADDR_W      = 21,
    parameter logic [ADDR_W-1:0] BANK0_BASE  = '0,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(21'h080000),
    parameter bit                VS_POL      = 1'b1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              cfg_done,
    input  logic              capture_en,
    input  logic              cmos_vsync,
    input  logic [15:0]       pix_data,
    input  logic              pix_valid,
    input  logic              wr_ready,
    output logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic              disp_bank,
    output logic [15:0]       frame_cnt
);

    localparam logic [ADDR_W-1:0] FRAME_PIXELS = ADDR_W'(frame_pixels(H_ACT, V_ACT));
    localparam logic [15:0]       SKIP_CNT_MAX = 16'(SKIP_FRAMES);

    logic vs_start;
    logic vs_end;

    ov5640_vsync_edge #(
        .VS_POL(VS_POL)
    ) u_vsync_edge (
        .sysclk    (sysclk),
        .rst       (rst),
        .cmos_vsync(cmos_vsync),
        .vs_start  (vs_start),
        .vs_end    (vs_end)
    );

    cap_state_t        state_reg,       state_next;
    logic [15:0]       skip_cnt_reg,    skip_cnt_next;
    logic [ADDR_W-1:0] pix_idx_reg,     pix_idx_next;
    logic              ovf_reg,         ovf_next;
    logic              cnt_err_reg,     cnt_err_next;
    logic              first_reg,       first_next;
    logic              wr_bank_reg,     wr_bank_next;
    logic              disp_bank_reg,   disp_bank_next;
    logic [15:0]       frame_cnt_reg,   frame_cnt_next;
    logic              wr_valid_reg,    wr_valid_next;
    logic [15:0]       wr_data_reg,     wr_data_next;
    logic [ADDR_W-1:0] wr_addr_reg,     wr_addr_next;
    logic              frame_start_reg, frame_start_next;
    logic              frame_done_reg,  frame_done_next;
    logic              frame_err_reg,   frame_err_next;
`ifdef CAPTURE_DECIM_EN
    logic              decim_tgl_reg,   decim_tgl_next;
`endif

    logic [ADDR_W-1:0] bank_base;
    logic              frame_bad;

    assign bank_base = wr_bank_reg ? BANK1_BASE : BANK0_BASE;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_reg       <= IDLE;
            skip_cnt_reg    <= '0;
            pix_idx_reg     <= '0;
            ovf_reg         <= 1'b0;
            cnt_err_reg     <= 1'b0;
            first_reg       <= 1'b0;
            wr_bank_reg     <= 1'b0;
            disp_bank_reg   <= 1'b0;
            frame_cnt_reg   <= '0;
            wr_valid_reg    <= 1'b0;
            wr_data_reg     <= '0;
            wr_addr_reg     <= '0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
`ifdef CAPTURE_DECIM_EN
            decim_tgl_reg   <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            skip_cnt_reg    <= skip_cnt_next;
            pix_idx_reg     <= pix_idx_next;
            ovf_reg         <= ovf_next;
            cnt_err_reg     <= cnt_err_next;
            first_reg       <= first_next;
            wr_bank_reg     <= wr_bank_next;
            disp_bank_reg   <= disp_bank_next;
            frame_cnt_reg   <= frame_cnt_next;
            wr_valid_reg    <= wr_valid_next;
            wr_data_reg     <= wr_data_next;
            wr_addr_reg     <= wr_addr_next;
            frame_start_reg <= frame_start_next;
            frame_done_reg  <= frame_done_next;
            frame_err_reg   <= frame_err_next;
`ifdef CAPTURE_DECIM_EN
            decim_tgl_reg   <= decim_tgl_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        skip_cnt_next    = skip_cnt_reg;
        pix_idx_next     = pix_idx_reg;
        ovf_next         = ovf_reg;
        cnt_err_next     = cnt_err_reg;
        first_next       = first_reg;
        wr_bank_next     = wr_bank_reg;
        disp_bank_next   = disp_bank_reg;
        frame_cnt_next   = frame_cnt_reg;
        wr_valid_next    = 1'b0;
        wr_data_next     = wr_data_reg;
        wr_addr_next     = wr_addr_reg;
        frame_start_next = 1'b0;
        frame_done_next  = 1'b0;
        frame_err_next   = 1'b0;
`ifdef CAPTURE_DECIM_EN
        decim_tgl_next   = decim_tgl_reg;
`endif
        // pix_idx saturates, so overrun is tracked separately in cnt_err.
        frame_bad = ovf_reg | cnt_err_reg | (pix_idx_reg != FRAME_PIXELS);

        if (!cfg_done) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next    = SKIP;
                    skip_cnt_next = '0;
                end
                SKIP: begin
                    if (skip_cnt_reg >= SKIP_CNT_MAX) begin
                        state_next = ARM;
`ifdef CAPTURE_DECIM_EN
                        decim_tgl_next = 1'b0;
`endif
                    end else if (vs_end) begin
                        skip_cnt_next = skip_cnt_reg + 16'd1;
                    end
                end
                ARM: begin
                    if (vs_start) begin
`ifdef CAPTURE_DECIM_EN
                        decim_tgl_next = !decim_tgl_reg;
                        if (capture_en && !decim_tgl_reg) begin
`else
                        if (capture_en) begin
`endif
                            state_next   = CAPT;
                            pix_idx_next = '0;
                            ovf_next     = 1'b0;
                            cnt_err_next = 1'b0;
                            first_next   = 1'b1;
                        end
                    end
                end
                CAPT: begin
                    if (pix_valid) begin
                        frame_start_next = first_reg;
                        first_next       = 1'b0;
                        if (pix_idx_reg == FRAME_PIXELS) begin
                            cnt_err_next = 1'b1;
                        end else begin
                            // Index advances even on a drop so later pixels keep their slot.
                            pix_idx_next = pix_idx_reg + ADDR_W'(1);
                            if (wr_ready) begin
                                wr_valid_next = 1'b1;
                                wr_data_next  = pix_data;
                                wr_addr_next  = bank_base + pix_idx_reg;
                            end else begin
                                ovf_next = 1'b1;
                            end
                        end
                    end
                    if (vs_end) begin
                        state_next = CLOSE;
                    end
                end
                CLOSE: begin
                    frame_done_next = 1'b1;
                    frame_err_next  = frame_bad;
                    if (!frame_bad) begin
                        disp_bank_next = wr_bank_reg;
                        wr_bank_next   = !wr_bank_reg;
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                    end
                    state_next = ARM;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign wr_data     = wr_data_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_valid    = wr_valid_reg;
    assign frame_start = frame_start_reg;
    assign frame_done  = frame_done_reg;
    assign frame_err   = frame_err_reg;
    assign disp_bank   = disp_bank_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_ov5640_capture_ctrl.sv
// Scoreboarded directed bench for ov5640_capture_ctrl on a 4x2 frame with two
// settling frames; expected writes and frame results are queued as driven.
module tb_ov5640_capture_ctrl;

    localparam int         FP    = 8;
    localparam logic [20:0] BANK0 = 21'h000000;
    localparam logic [20:0] BANK1 = 21'h080000;

    typedef struct packed {
        logic [20:0] addr;
        logic [15:0] data;
        logic        first;
    } wr_exp_t;

    typedef struct packed {
        logic        err;
        logic        disp;
        logic [15:0] cnt;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_done;
    logic        capture_en;
    logic        vsync;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [20:0] wr_addr;
    logic        wr_valid;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic        disp_bank;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    int seq = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic        exp_bank = 1'b0;
    logic        exp_disp = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];
    wr_exp_t   mon_we;
    done_exp_t mon_de;

    ov5640_capture_ctrl #(
        .H_ACT      (4),
        .V_ACT      (2),
        .SKIP_FRAMES(2)
    ) dut (
        .sysclk     (clk),
        .rst        (rst),
        .cfg_done   (cfg_done),
        .capture_en (capture_en),
        .cmos_vsync (vsync),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .wr_valid   (wr_valid),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .disp_bank  (disp_bank),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sensor frame: blanking exit, n_pix pixels, blanking entry.
    task automatic run_frame(input int n_pix, input bit cap, input int drop_idx,
                             input int en_at, input bit abort);
        logic [20:0] base;
        logic        err;
        wr_exp_t     e;
        base = exp_bank ? BANK1 : BANK0;
        vsync = 1'b0;
        tick();
        tick();
        for (int i = 0; i < n_pix; i++) begin
            if (i == en_at) capture_en = 1'b1;
            pix_valid = 1'b1;
            pix_data  = {seq[7:0], 8'(i)};
            wr_ready  = (i != drop_idx);
            if (cap && i < FP && i != drop_idx) begin
                e.addr  = base + 21'(i);
                e.data  = pix_data;
                e.first = (i == 0);
                wr_q.push_back(e);
            end
            tick();
        end
        pix_valid = 1'b0;
        wr_ready  = 1'b1;
        seq++;
        tick();
        if (abort) begin
            cfg_done = 1'b0;
            repeat (3) tick();
            vsync = 1'b1;
            repeat (3) tick();
            cfg_done = 1'b1;
            repeat (2) tick();
        end else begin
            tick();
            vsync = 1'b1;
            if (cap) begin
                err = (drop_idx >= 0 && drop_idx < n_pix) || (n_pix != FP);
                if (!err) begin
                    exp_disp = exp_bank;
                    exp_bank = !exp_bank;
                    exp_cnt  = exp_cnt + 16'd1;
                end
                done_q.push_back({err, exp_disp, exp_cnt});
                exp_done++;
            end
            repeat (4) tick();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_start) chk("start_has_wr", 32'(wr_valid), 32'd1);
            if (wr_valid) begin
                chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    mon_we = wr_q.pop_front();
                    $display("write addr=%06h data=%04h start=%0b", wr_addr, wr_data, frame_start);
                    chk("wr_addr", 32'(wr_addr), 32'(mon_we.addr));
                    chk("wr_data", 32'(wr_data), 32'(mon_we.data));
                    chk("frame_start", 32'(frame_start), 32'(mon_we.first));
                end
            end
            if (frame_done) begin
                done_seen++;
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    mon_de = done_q.pop_front();
                    $display("frame_done err=%0b disp_bank=%0b frame_cnt=%0d", frame_err, disp_bank, frame_cnt);
                    chk("frame_err", 32'(frame_err), 32'(mon_de.err));
                    chk("disp_bank", 32'(disp_bank), 32'(mon_de.disp));
                    chk("frame_cnt", 32'(frame_cnt), 32'(mon_de.cnt));
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        cfg_done   = 1'b0;
        capture_en = 1'b1;
        vsync      = 1'b1;
        pix_data   = '0;
        pix_valid  = 1'b0;
        wr_ready   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_disp_bank", 32'(disp_bank), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        cfg_done = 1'b1;
        tick();

        run_frame(8, 1'b0, -1, -1, 1'b0);
        run_frame(8, 1'b0, -1, -1, 1'b0);
`ifdef CAPTURE_DECIM_EN
        for (int k = 0; k < 6; k++) begin
            run_frame(8, (k % 2) == 0, -1, -1, 1'b0);
        end
`else
        run_frame(8, 1'b1, -1, -1, 1'b0);   // bank 0, good
        run_frame(8, 1'b1, -1, -1, 1'b0);   // bank 1, good
        run_frame(8, 1'b1, 3, -1, 1'b0);    // overflow at pixel 3
        run_frame(6, 1'b1, -1, -1, 1'b0);   // short frame
        run_frame(8, 1'b1, -1, -1, 1'b0);   // same bank reused, good
        capture_en = 1'b0;
        run_frame(8, 1'b0, -1, 2, 1'b0);    // enable raised mid-frame
        run_frame(8, 1'b1, -1, -1, 1'b0);
        run_frame(3, 1'b1, -1, -1, 1'b1);   // cfg_done dropped mid-capture
        run_frame(8, 1'b0, -1, -1, 1'b0);
        run_frame(8, 1'b0, -1, -1, 1'b0);
        run_frame(8, 1'b1, -1, -1, 1'b0);
        run_frame(9, 1'b1, -1, -1, 1'b0);   // overrun beyond frame size
`endif
        repeat (5) tick();
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(exp_done));
        chk("final_disp_bank", 32'(disp_bank), 32'(exp_disp));
        chk("final_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
